// File: rtl/regfile_sys_ctrl.sv
// regfile_sys_ctrl: byte-stream command controller in front of the register file.
// Parses write frames (WR_CMD, addr, NB data bytes LSB first) and read frames
// (RD_CMD, addr), drives RdEn/WrEn/Address/WrData, and returns read data
// byte-serially over a tx valid/ready handshake.
// Optional build macro: WR_ACK_EN (adds an ACK byte after every write).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a command byte, other bytes ignored
// WR_ADDR   | waiting for the write address byte
// WR_DATA   | collecting NB write data bytes, LSB first
// WR_EXEC   | WrEn high for one cycle
// RD_ADDR   | waiting for the read address byte
// RD_EXEC   | RdEn high for one cycle
// RD_CAPT   | register file RdData valid, captured into shift register
// TX_SEND   | returning captured bytes, LSB first
// ACK       | returning ACK_BYTE after a write (WR_ACK_EN only)

module regfile_sys_ctrl #(
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 3,
    parameter logic [7:0]  WR_CMD = 8'hAA,
    parameter logic [7:0]  RD_CMD = 8'hBB
`ifdef WR_ACK_EN
    ,
    parameter logic [7:0]  ACK_BYTE = 8'h5A
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              RdEn,
    output logic              WrEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              rx_drop
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_EXEC,
        S_RD_ADDR,
        S_RD_EXEC,
        S_RD_CAPT,
        S_TX_SEND
`ifdef WR_ACK_EN
        ,
        S_ACK
`endif
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   cap_q;
    logic [DATA_W-1:0]   cap_shift_d;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                rx_drop_q;
    logic                rx_drop_d;

    assign cap_shift_d = cap_q >> 8;

    // Bytes arriving while the FSM is busy executing or transmitting are discarded.
    always_comb begin
        rx_drop_d = 1'b0;
        case (state_q)
            S_WR_EXEC, S_RD_EXEC, S_RD_CAPT, S_TX_SEND: rx_drop_d = rx_valid;
`ifdef WR_ACK_EN
            S_ACK:                                      rx_drop_d = rx_valid;
`endif
            default:                                    rx_drop_d = 1'b0;
        endcase
    end

    // Frame parser, bus sequencing and tx serializer with registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            cap_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            rx_drop_q <= rx_drop_d;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == WR_CMD)      state_q <= S_WR_ADDR;
                        else if (rx_data == RD_CMD) state_q <= S_RD_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    if (rx_valid) begin
                        addr_q  <= rx_data[ADDR_W-1:0];
                        cnt_q   <= '0;
                        state_q <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (rx_valid) begin
                        wr_data_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                        if (cnt_q == CNT_LAST) begin
                            wr_en_q <= 1'b1;
                            state_q <= S_WR_EXEC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_WR_EXEC: begin
                    wr_en_q <= 1'b0;
`ifdef WR_ACK_EN
                    tx_data_q  <= ACK_BYTE;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_ACK;
`else
                    state_q    <= S_IDLE;
`endif
                end
                S_RD_ADDR: begin
                    if (rx_valid) begin
                        addr_q  <= rx_data[ADDR_W-1:0];
                        rd_en_q <= 1'b1;
                        state_q <= S_RD_EXEC;
                    end
                end
                S_RD_EXEC: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_RD_CAPT;
                end
                S_RD_CAPT: begin
                    cap_q      <= RdData;
                    tx_data_q  <= RdData[7:0];
                    tx_valid_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= S_TX_SEND;
                end
                S_TX_SEND: begin
                    if (tx_ready) begin
                        if (cnt_q == CNT_LAST) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            cap_q     <= cap_shift_d;
                            tx_data_q <= cap_shift_d[7:0];
                        end
                    end
                end
`ifdef WR_ACK_EN
                S_ACK: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RdEn     = rd_en_q;
    assign WrEn     = wr_en_q;
    assign Address  = addr_q;
    assign WrData   = wr_data_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign rx_drop  = rx_drop_q;

endmodule

// File: doc/regfile_sys_ctrl.md
Name: regfile_sys_ctrl

Overview:
Command controller that sits directly upstream of the register file and drives its RdEn/WrEn/Address/WrData bus. It parses a byte stream from the UART receiver into register write and read commands. For a read, it captures the register file's RdData and returns it byte-serially to the UART transmitter over a valid/ready handshake.

Parameters:
DATA_W, 16, register width; multiple of 8; equals the register file WIDTH.
ADDR_W, 3, register address width; equals the register file AddrW.
WR_CMD, 8'hAA, command byte that opens a write frame.
RD_CMD, 8'hBB, command byte that opens a read frame.
ACK_BYTE, 8'h5A, byte returned after a write (optional feature only).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
RdEn  out  1  register file read enable
WrEn  out  1  register file write enable
Address  out  ADDR_W  register file address
WrData  out  DATA_W  register file write data
RdData  in  DATA_W  register file read data, registered, valid 1 cycle after RdEn
tx_data  out  8  byte to the transmitter
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
rx_drop  out  1  one-cycle pulse: an rx byte was discarded

Behaviour:
- Frame formats, bytes in arrival order, multi-byte data LSB first. NB = DATA_W/8.
  - Write frame: WR_CMD, addr, then NB data bytes.
  - Read frame: RD_CMD, addr.
- Address = addr byte [ADDR_W-1:0]; upper bits are ignored.
- Reset (RST low, asynchronous) forces:
  - state IDLE; byte counter 0
  - RdEn, WrEn, tx_valid, rx_drop = 0
  - Address, WrData, tx_data, internal capture register = 0
- RST low mid-frame or mid-transmit aborts the frame silently.
- FSM states and transitions:
  - IDLE: on rx_valid, WR_CMD -> WR_ADDR; RD_CMD -> RD_ADDR. Any other byte is ignored (no rx_drop).
  - WR_ADDR: on rx_valid, latch Address -> WR_DATA; byte counter = 0.
  - WR_DATA: each rx_valid loads WrData byte[cnt], cnt++. After byte NB-1 -> WR_EXEC.
  - WR_EXEC: WrEn=1 and RdEn=0 for exactly one cycle, with Address/WrData stable -> IDLE (or ACK, see Optional Feature).
  - RD_ADDR: on rx_valid, latch Address -> RD_EXEC.
  - RD_EXEC: RdEn=1 and WrEn=0 for one cycle -> RD_CAPT.
  - RD_CAPT: capture RdData into the shift register -> TX_SEND; cnt = 0.
  - TX_SEND: tx_data = capture byte[cnt], tx_valid=1. On tx_valid && tx_ready, cnt++. After byte NB-1 is accepted -> IDLE, with tx_valid=0 in the following cycle.
- Enables:
  - RdEn and WrEn are never high in the same cycle.
  - Both are 0 in every state except RD_EXEC and WR_EXEC respectively.
- Latency:
  - Last write byte strobe to WrEn high: 1 cycle.
  - Address byte strobe to first tx_valid: 3 cycles (RD_EXEC, RD_CAPT, TX_SEND).
- tx_data and tx_valid are stable while tx_valid && !tx_ready.
- Dropped bytes: rx_valid during WR_EXEC, RD_EXEC, RD_CAPT, TX_SEND or ACK discards the byte and pulses rx_drop the next cycle. No state change.
- No timeout; a partial frame waits indefinitely.

Optional Feature:
- Macro WR_ACK_EN.
- Defined: after WR_EXEC the FSM enters ACK and drives tx_data=ACK_BYTE, tx_valid=1 until accepted, then returns to IDLE.
- Undefined: WR_EXEC returns directly to IDLE, no ACK state exists, and writes produce no tx traffic.

Test Plan:
- Reset mid-transmit: send BB 02, stall tx_ready=0, pulse RST low -> tx_valid=0, state IDLE; a following BB 02 frame works normally.
- Write: send AA 05 34 12 -> single-cycle WrEn with Address=5, WrData=16'h1234, RdEn=0. With WR_ACK_EN, tx byte 5A.
- Readback: write AA 03 CD AB, then BB 03 -> RdEn pulse with Address=3, then tx bytes CD then AB. Check RdEn-to-capture timing and tx_valid hold under random tx_ready stalls.
- Junk and truncation: send 11 then AA 0F (address truncates to 7) then 01 02 -> 11 ignored, WrEn at Address=7, WrData=16'h0201.
- Overrun: during TX_SEND with tx_ready=0, inject rx byte 77 -> rx_drop pulses once, the tx sequence is unaffected, and the next frame parses correctly.
